data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl_if.sv | 22 ++
 rtl/data_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Datapath-to-data-memory bus: load/store request and response.
// The datapath (master) drives requests; the controller (slave) answers.
interface data_mem_ctrl_if;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] ReadData;
  logic        stall;
  logic        ready;
  logic        err;

  modport master (
    output MemRead, MemWrite, addr, wdata,
    input  ReadData, stall, ready, err
  );

  modport slave (
    input  MemRead, MemWrite, addr, wdata,
    output ReadData, stall, ready, err
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-addressed data memory with a fixed wait-state count per access.
// Stalls the datapath until the access completes; flags misaligned requests.
module data_mem_ctrl #(
  parameter int DEPTH = 64,
  parameter int WAIT  = 2
) (
  input  logic         clk,
  input  logic         rst,
  data_mem_ctrl_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [3:0]      cnt;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic            we_q;
  logic [31:0]     ram [DEPTH];

  logic            req;
  logic            aligned;
  logic            accept;
  logic            enter_done;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic            acc_we;
  logic            unused_addr;

  assign req        = bus.MemRead | bus.MemWrite;
  assign aligned    = (bus.addr[1:0] == 2'b00);
  assign accept     = (state == IDLE) && req && aligned;
  assign enter_done = (state_nxt == DONE);

  // A zero-wait access completes straight from IDLE, so use live inputs there
  assign acc_idx   = (state == IDLE) ? bus.addr[AW+1:2] : idx_q;
  assign acc_wdata = (state == IDLE) ? bus.wdata : wdata_q;
  assign acc_we    = (state == IDLE) ? bus.MemWrite : we_q;

  assign unused_addr = ^bus.addr[31:AW+2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (WAIT == 0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.stall = 1'b0;
    bus.ready = 1'b0;
    unique case (state)
      IDLE:    bus.stall = accept;
      BUSY:    bus.stall = 1'b1;
      DONE:    bus.ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 4'd0;
      idx_q        <= '0;
      wdata_q      <= 32'd0;
      we_q         <= 1'b0;
      bus.ReadData <= 32'd0;
      bus.err      <= 1'b0;
    end else begin
      if (accept) begin
        cnt     <= CNT_INIT;
        idx_q   <= bus.addr[AW+1:2];
        wdata_q <= bus.wdata;
        we_q    <= bus.MemWrite;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_done && !acc_we) begin
        bus.ReadData <= ram[acc_idx];
      end
      if (state == IDLE && req && !aligned) begin
        bus.err <= 1'b1;
      end
    end
  end

  // Storage is deliberately not reset so contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (enter_done && acc_we) begin
      ram[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with WAIT=2, DEPTH=64.
// Inputs change 1 time unit after posedge; outputs sampled at negedge.
module tb_data_mem_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  data_mem_ctrl_if bus ();

  data_mem_ctrl #(
    .DEPTH (64),
    .WAIT  (2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] b(input logic v);
    return {31'd0, v};
  endfunction

  // Starts at posedge+1 (cycle 0), ends at posedge+1 after cycle 4.
  task automatic do_access(
    input logic        wr,
    input logic        rd,
    input logic [31:0] a,
    input logic [31:0] d,
    input logic [31:0] exp_rd
  );
    bus.MemWrite = wr;
    bus.MemRead  = rd;
    bus.addr     = a;
    bus.wdata    = d;
    @(negedge clk);
    check("stall_c0", b(bus.stall), 32'd1);
    check("ready_c0", b(bus.ready), 32'd0);
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.addr     = a ^ 32'h4;
    bus.wdata    = ~d;
    @(negedge clk);
    check("stall_c1", b(bus.stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("stall_c2", b(bus.stall), 32'd1);
    check("ready_c2", b(bus.ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ready_c3", b(bus.ready), 32'd1);
    check("stall_c3", b(bus.stall), 32'd0);
    check("rdata_c3", bus.ReadData, exp_rd);
    @(posedge clk);
    @(negedge clk);
    check("ready_c4", b(bus.ready), 32'd0);
    check("stall_c4", b(bus.stall), 32'd0);
    check("rdata_c4", bus.ReadData, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic misaligned_store(input logic [31:0] a);
    bus.MemWrite = 1'b1;
    bus.MemRead  = 1'b0;
    bus.addr     = a;
    bus.wdata    = 32'hFFFF_FFFF;
    @(negedge clk);
    check("mis_stall", b(bus.stall), 32'd0);
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
    @(negedge clk);
    check("mis_err", b(bus.err), 32'd1);
    check("mis_stall2", b(bus.stall), 32'd0);
    check("mis_ready", b(bus.ready), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst          = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;

    #3;
    check("rst_rdata", bus.ReadData, 32'd0);
    check("rst_stall", b(bus.stall), 32'd0);
    check("rst_ready", b(bus.ready), 32'd0);
    check("rst_err", b(bus.err), 32'd0);

    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    do_access(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0);
    do_access(1'b0, 1'b1, 32'h10, 32'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    check("rdata_hold", bus.ReadData, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    bus.wdata = 32'h0;
    do_access(1'b0, 1'b1, 32'h110, 32'd0, 32'hDEAD_BEEF);

    // Both strobes high: must behave as a store only
    do_access(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, 32'hDEAD_BEEF);
    do_access(1'b0, 1'b1, 32'h20, 32'd0, 32'hA5A5_A5A5);

    misaligned_store(32'h12);
    do_access(1'b0, 1'b1, 32'h10, 32'd0, 32'hDEAD_BEEF);
    check("err_sticky", b(bus.err), 32'd1);

    // Store aborted by reset in cycle 1
    bus.MemWrite = 1'b1;
    bus.addr     = 32'h10;
    bus.wdata    = 32'h1234_5678;
    @(posedge clk); #1;
    bus.MemWrite = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_stall", b(bus.stall), 32'd0);
    check("abort_ready", b(bus.ready), 32'd0);
    check("abort_rdata", bus.ReadData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(1'b0, 1'b1, 32'h10, 32'd0, 32'hDEAD_BEEF);

    // Mid-cycle reset clears outputs at once; RAM survives it
    misaligned_store(32'h23);
    do_access(1'b0, 1'b1, 32'h20, 32'd0, 32'hA5A5_A5A5);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rdata", bus.ReadData, 32'd0);
    check("mid_err", b(bus.err), 32'd0);
    check("mid_stall", b(bus.stall), 32'd0);
    check("mid_ready", b(bus.ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    do_access(1'b0, 1'b1, 32'h20, 32'd0, 32'hA5A5_A5A5);
    check("err_clear", b(bus.err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
